// File: rtl/expmu_scheduler.sv
// Round-robin scheduler sharing one CalculateExpMu datapath between N_REQ parameter sets:
// latches the winner's mu/S0, launches the sweep, forwards tagged write-back, then acks or errors.
module expmu_scheduler #(
  parameter int N_REQ   = 4,
  parameter int logN    = 2,
  parameter int logT    = 9,
  parameter int DRAIN   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                      CLK,
  input  logic                      iReset,
  input  logic [N_REQ-1:0]          iReq,
  input  logic [18*N_REQ-1:0]       iMuBus,
  input  logic [18*N_REQ-1:0]       iSBus,
  output logic [N_REQ-1:0]          oGrant,
  output logic [N_REQ-1:0]          oAck,
  output logic [N_REQ-1:0]          oErr,
  output logic                      oBusy,
  output logic                      oDpStart,
  output logic [17:0]               oDpMu,
  output logic [17:0]               oDpS,
  input  logic [17:0]               iDpData,
  input  logic [logT-1:0]           iDpAddr,
  input  logic                      iDpDone,
  output logic                      oWrEn,
  output logic [logN+logT-1:0]      oWrAddr,
  output logic [17:0]               oWrData,
  output logic [2:0]                oDbgState
);

  // Handshake: iReq[k] is a level held by requester k until it sees oAck[k] or oErr[k];
  // the scheduler owns the datapath (oGrant[k]) from LAUNCH through ACK and never
  // drops a granted sweep, even if the request falls away meanwhile.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  localparam int CW = (TIMEOUT > DRAIN) ? $clog2(TIMEOUT) : $clog2(DRAIN);

  state_t                 state_q;
  logic [logN-1:0]        ptr_q;
  logic [logN-1:0]        idx_q;
  logic [CW-1:0]          cnt_q;
  logic [N_REQ-1:0]       grant_q;
  logic [N_REQ-1:0]       ack_q;
  logic [N_REQ-1:0]       err_q;
  logic                   start_q;
  logic [17:0]            mu_q;
  logic [17:0]            s_q;
  logic                   wr_en_q;
  logic [logN+logT-1:0]   wr_addr_q;
  logic [17:0]            wr_data_q;

  logic                   pick_vld_d;
  logic [logN-1:0]        pick_idx_d;
  logic [logN:0]          slot;

  logic [17:0]            mu_slot [N_REQ];
  logic [17:0]            s_slot  [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    assign mu_slot[g] = iMuBus[18*g +: 18];
    assign s_slot[g]  = iSBus[18*g +: 18];
  end

  // Scan downward so the slot closest to ptr (smallest offset) is written last and wins.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    slot       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      slot = {1'b0, ptr_q} + (logN+1)'(i);
      if (slot >= (logN+1)'(N_REQ)) slot = slot - (logN+1)'(N_REQ);
      if (iReq[slot[logN-1:0]]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = slot[logN-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (iReset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      start_q   <= 1'b0;
      mu_q      <= '0;
      s_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
      err_q   <= '0;
      wr_en_q <= (state_q == S_RUN) || (state_q == S_DRAIN);
      if ((state_q == S_RUN) || (state_q == S_DRAIN)) begin
        wr_addr_q <= {idx_q, iDpAddr};
        wr_data_q <= iDpData;
      end
      case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            idx_q   <= pick_idx_d;
            grant_q <= N_REQ'(1) << pick_idx_d;
            mu_q    <= mu_slot[pick_idx_d];
            s_q     <= s_slot[pick_idx_d];
            start_q <= 1'b1;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (iDpDone) begin
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_q   <= grant_q;
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DRAIN: begin
          // Keep write-back open while the mult/exp/mult pipeline flushes.
          if (cnt_q == CW'(DRAIN - 1)) begin
            ack_q   <= grant_q;
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_ACK: begin
          grant_q <= '0;
          ptr_q   <= (idx_q == logN'(N_REQ - 1)) ? '0 : idx_q + logN'(1);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oGrant    = grant_q;
  assign oAck      = ack_q;
  assign oErr      = err_q;
  assign oBusy     = (state_q != S_IDLE);
  assign oDpStart  = start_q;
  assign oDpMu     = mu_q;
  assign oDpS      = s_q;
  assign oWrEn     = wr_en_q;
  assign oWrAddr   = wr_addr_q;
  assign oWrData   = wr_data_q;
  assign oDbgState = state_q;

endmodule

// File: tb/tb_expmu_scheduler.sv
// Bench for expmu_scheduler: a behavioural datapath drives sweeps of chosen length while a
// round-robin model and an expected write queue predict grants, parameters, writes and acks.
module tb_expmu_scheduler;

  localparam int N_REQ   = 4;
  localparam int LOGN    = 2;
  localparam int LOGT    = 9;
  localparam int DRAIN   = 8;
  localparam int TIMEOUT = 256;
  localparam int W       = LOGN + LOGT + 18;

  logic                   CLK = 1'b0;
  logic                   iReset;
  logic [N_REQ-1:0]       iReq;
  logic [18*N_REQ-1:0]    iMuBus;
  logic [18*N_REQ-1:0]    iSBus;
  logic [N_REQ-1:0]       oGrant;
  logic [N_REQ-1:0]       oAck;
  logic [N_REQ-1:0]       oErr;
  logic                   oBusy;
  logic                   oDpStart;
  logic [17:0]            oDpMu;
  logic [17:0]            oDpS;
  logic [17:0]            iDpData;
  logic [LOGT-1:0]        iDpAddr;
  logic                   iDpDone;
  logic                   oWrEn;
  logic [LOGN+LOGT-1:0]   oWrAddr;
  logic [17:0]            oWrData;
  logic [2:0]             dbg_state;

  logic [W-1:0]           exp_q[$];
  int                     n_vec = 0;
  int                     n_err = 0;
  int                     ptr_m = 0;
  logic [17:0]            mu_m [N_REQ];
  logic [17:0]            s_m  [N_REQ];

  expmu_scheduler #(
    .N_REQ(N_REQ), .logN(LOGN), .logT(LOGT), .DRAIN(DRAIN), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .iReset(iReset), .iReq(iReq), .iMuBus(iMuBus), .iSBus(iSBus),
    .oGrant(oGrant), .oAck(oAck), .oErr(oErr), .oBusy(oBusy), .oDpStart(oDpStart),
    .oDpMu(oDpMu), .oDpS(oDpS), .iDpData(iDpData), .iDpAddr(iDpAddr), .iDpDone(iDpDone),
    .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData), .oDbgState(dbg_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N_REQ-1:0] req, input int ptr);
    for (int i = 0; i < N_REQ; i++)
      if (req[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
    return 0;
  endfunction

  // Driver tasks
  task automatic randomize_params();
    for (int k = 0; k < N_REQ; k++) begin
      mu_m[k] = 18'($urandom);
      s_m[k]  = 18'($urandom);
    end
  endtask

  task automatic drive_buses();
    for (int k = 0; k < N_REQ; k++) begin
      iMuBus[18*k +: 18] = mu_m[k];
      iSBus[18*k +: 18]  = s_m[k];
    end
  endtask

  task automatic check_reset_vals();
    check_eq("rst_grant", oGrant, 0);
    check_eq("rst_ack", oAck, 0);
    check_eq("rst_err", oErr, 0);
    check_eq("rst_busy", oBusy, 0);
    check_eq("rst_start", oDpStart, 0);
    check_eq("rst_mu", oDpMu, 0);
    check_eq("rst_s", oDpS, 0);
    check_eq("rst_wren", oWrEn, 0);
    check_eq("rst_wraddr", oWrAddr, 0);
    check_eq("rst_wrdata", oWrData, 0);
    check_eq("rst_state", dbg_state, 0);
  endtask

  // One granted sweep, entered at a negedge where the DUT is idle. len = RUN cycle on
  // which done pulses; tmo = done never pulses; rst_at > 0 = reset at that sweep cycle.
  task automatic sweep(input logic [N_REQ-1:0] req, input int len, input bit tmo, input int rst_at);
    int               w;
    int               cap_end;
    logic [17:0]      emu;
    logic [17:0]      es;
    logic [N_REQ-1:0] gmask;
    logic [LOGT-1:0]  a;
    logic [17:0]      d;
    logic [W-1:0]     e;
    iReq = req;
    drive_buses();
    iDpDone = 1'($urandom_range(0, 1));
    iDpAddr = LOGT'($urandom);
    iDpData = 18'($urandom);
    w       = rr_pick(req, ptr_m);
    emu     = mu_m[w];
    es      = s_m[w];
    gmask   = N_REQ'(1) << w;
    cap_end = tmo ? TIMEOUT : len + DRAIN;
    @(negedge CLK);
    check_eq("launch_start", oDpStart, 1);
    check_eq("launch_grant", oGrant, gmask);
    check_eq("launch_mu", oDpMu, emu);
    check_eq("launch_s", oDpS, es);
    check_eq("launch_wren", oWrEn, 0);
    for (int o = 0; o <= cap_end + 1; o++) begin
      if (o > 0) begin
        @(negedge CLK);
        check_eq("start_low", oDpStart, 0);
        check_eq("grant_hold", oGrant, gmask);
        check_eq("mu_hold", oDpMu, emu);
        check_eq("s_hold", oDpS, es);
        check_eq("busy", oBusy, 1);
        check_eq("ack", oAck, (!tmo && o == cap_end + 1) ? gmask : '0);
        check_eq("err", oErr, (tmo && o == cap_end + 1) ? gmask : '0);
        check_eq("wr_en", oWrEn, (o >= 2));
        if (oWrEn) begin
          check_eq("wr_q_nonempty", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("wr_word", {oWrAddr, oWrData}, e);
          end
        end
      end
      if (rst_at > 0 && o == rst_at) begin
        iReset = 1'b1;
        iReq   = '0;
        @(negedge CLK);
        check_reset_vals();
        iReset = 1'b0;
        exp_q.delete();
        ptr_m = 0;
        for (int c = 0; c < 12; c++) begin
          iDpDone = 1'($urandom_range(0, 1));
          iDpAddr = LOGT'($urandom);
          iDpData = 18'($urandom);
          @(negedge CLK);
          check_eq("post_rst_wren", oWrEn, 0);
          check_eq("post_rst_ack", oAck, 0);
          check_eq("post_rst_err", oErr, 0);
          check_eq("post_rst_busy", oBusy, 0);
        end
        return;
      end
      a = LOGT'($urandom);
      d = 18'($urandom);
      iDpAddr = a;
      iDpData = d;
      if (o >= 1 && o <= cap_end) begin
        exp_q.push_back({LOGN'(w), a, d});
        if (tmo || o < len) iDpDone = 1'b0;
        else if (o == len)  iDpDone = 1'b1;
        else                iDpDone = 1'($urandom_range(0, 1));
      end else begin
        iDpDone = 1'($urandom_range(0, 1));
      end
      if (o == 3) begin
        randomize_params();
        drive_buses();
      end
      if (o == 4) iReq = N_REQ'($urandom);
    end
    ptr_m = (w + 1) % N_REQ;
    check_eq("q_drained", exp_q.size(), 0);
    @(negedge CLK);
    check_eq("idle_busy", oBusy, 0);
    check_eq("idle_grant", oGrant, 0);
    check_eq("idle_ack", oAck, 0);
    check_eq("idle_err", oErr, 0);
    check_eq("idle_wren", oWrEn, 0);
  endtask

  initial begin
    iReset  = 1'b1;
    iReq    = '0;
    iMuBus  = '0;
    iSBus   = '0;
    iDpData = '0;
    iDpAddr = '0;
    iDpDone = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_vals();
    iReset = 1'b0;
    @(negedge CLK);
    check_eq("idle_after_rst", oBusy, 0);

    randomize_params();
    mu_m[0] = 18'h00100;
    s_m[0]  = 18'h04000;
    sweep(4'b0001, 170, 1'b0, 0);

    randomize_params();
    sweep(4'b0110, 100, 1'b0, 20);

    // Held requests from ptr 0: grants 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      randomize_params();
      sweep(4'b1111, $urandom_range(1, 30), 1'b0, 0);
    end

    // Serve 3, then with 3 and 0 pending the pointer wraps to 0 before 3 again
    randomize_params();
    sweep(4'b1000, 12, 1'b0, 0);
    sweep(4'b1001, 5, 1'b0, 0);
    sweep(4'b1001, 5, 1'b0, 0);

    randomize_params();
    sweep(4'b0100, 0, 1'b1, 0);

    for (int i = 0; i < 8; i++) begin
      randomize_params();
      sweep(N_REQ'($urandom_range(1, 15)), $urandom_range(1, 40), 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/expmu_scheduler.md
# expmu_scheduler

Sequencing controller and round-robin arbiter that shares one CalculateExpMu datapath (S0·exp(t·mu) over the t-range) between N_REQ requesters, each an independent asset/parameter set. It latches the winning requester's mu and S0, pulses the datapath start, and holds both parameters stable for the whole sweep. It forwards the datapath's write-back stream, tagged with the requester index, to the shared result RAM, then acknowledges the requester. It sits between the per-asset parameter registers and the CalculateExpMu instance.

## Interface
- N_REQ, 4: number of requesters (2..16)
- logN, 2: ceil(log2(N_REQ))
- logT, 9: datapath address width
- DRAIN, 8: cycles write-back stays open after datapath done (pipeline flush of mult/exp/mult)
- TIMEOUT, 1024: max cycles in RUN before abort
- CLK  in  1  clock, all logic on rising edge
- iReset  in  1  synchronous, active-high reset
- iReq  in  N_REQ  level request per requester; held until matching oAck or oErr bit
- iMuBus  in  18*N_REQ  mu of requester k at bits [18k+17:18k], 18 fraction bits
- iSBus  in  18*N_REQ  S0 of requester k at [18k+17:18k], 4.14 format
- oGrant  out  N_REQ  one-hot, owner of datapath from LAUNCH through ACK; else 0
- oAck  out  N_REQ  one-cycle pulse on bit k when k's sweep is written back
- oErr  out  N_REQ  one-cycle pulse on bit k when k's sweep times out
- oBusy  out  1  high in any state except IDLE
- oDpStart  out  1  start pulse to datapath
- oDpMu  out  18  mu to datapath, registered
- oDpS  out  18  S0 to datapath, registered
- iDpData  in  18  datapath result
- iDpAddr  in  logT  datapath result address
- iDpDone  in  1  datapath sweep-complete pulse
- oWrEn  out  1  result RAM write enable
- oWrAddr  out  logN+logT  {owner index, iDpAddr}
- oWrData  out  18  iDpData passed through registered

## Operation
- States: IDLE, LAUNCH, RUN, DRAIN, ACK.
- IDLE: if iReq≠0, pick first set bit scanning from ptr upward with wrap; register index, oGrant, oDpMu, oDpS from that slot; -> LAUNCH. iReq=0 -> stay.
- LAUNCH: oDpStart=1 for exactly this cycle; clear run counter; -> RUN.
- RUN: oWrEn=1 each cycle; counter increments. iDpDone=1 -> DRAIN (counter reset). Counter reaching TIMEOUT-1 without done -> ACK with error flag set.
- DRAIN: oWrEn=1; after DRAIN cycles -> ACK.
- ACK: pulse oAck[idx] (or oErr[idx] if error flag); ptr <= idx+1 mod N_REQ; oGrant cleared; -> IDLE.
- Write path: oWrAddr={idx, iDpAddr}, oWrData=iDpData, both registered one cycle with oWrEn (enable computed from state in the same cycle as the captured data).
- oDpMu/oDpS change only on entering LAUNCH; iMuBus/iSBus changes during a sweep are ignored.
- Request dropped before grant: ignored. Request dropped while granted: sweep completes, ack still pulses.
- iDpDone outside RUN: ignored.

## Timing
- Reset values: state IDLE, ptr 0, oGrant 0, oAck 0, oErr 0, oBusy 0, oDpStart 0, oDpMu 0, oDpS 0, oWrEn 0, oWrAddr 0, oWrData 0.
- iReset mid-sweep: all of the above next edge; no ack/err emitted; datapath left to finish unobserved (no writes forwarded).
- Request seen in IDLE at edge n -> oDpStart high cycle n+1 -> RUN from n+2.
- Done seen at edge m -> DRAIN m+1..m+DRAIN -> oAck pulse cycle m+DRAIN+1 -> IDLE; next grant decided at m+DRAIN+2 earliest.
- Same requester re-asserting immediately loses to any other pending requester (round robin).
- Exactly one of oAck/oErr per grant; never both; never two bits.

## Test plan
- Single request: iReq=0001, mu=0x00100, S=0x4000 -> oDpStart one cycle, oDpMu=0x00100, oDpS=0x4000; model done after 170 cycles -> oWrEn for 170+DRAIN cycles, oWrAddr[10:9]=0, oAck=0001 once.
- Fairness: iReq=1111 held, ptr=0 -> grants 0,1,2,3,0 in order; each oAck one-hot matching preceding oGrant.
- Wrap: only requesters 3 and 0 asserted after serving 3 -> next grant 0, then 3.
- Timeout: TIMEOUT=64, iDpDone never pulses -> oErr[idx] at cycle 64 after RUN entry, no oAck, back to IDLE.
- Param stability: change iMuBus slot during RUN -> oDpMu unchanged until next LAUNCH.
- Reset mid-RUN: iReset at cycle 20 of sweep -> next cycle all outputs reset values, no oAck/oErr, iDpDone afterwards produces no write.
